// File: rtl/ddr4_cmd_arbiter_if.sv
// ddr4_cmd_arbiter_if
// Bundles the AXI-Stream style channels around the DDR4 command arbiter:
//   s0_cmd_* / s1_cmd_*     requester command beats (tdata, tvalid, tlast, tready)
//   s0_wdata_* / s1_wdata_* requester write-data beats (tdata, tvalid, tready)
//   m_cmd_*                 arbitrated command stream to the scheduler
//   m_wdata_*               steered write-data stream to the scheduler
// Modports:
//   slave  - the arbiter side (consumes requester streams, drives m_*)
//   master - the environment side (drives requester streams, consumes m_*)
interface ddr4_cmd_arbiter_if #(
    parameter int CMD_WIDTH   = 128,
    parameter int WDATA_WIDTH = 512
);
    logic [CMD_WIDTH-1:0]   s0_cmd_tdata,   s1_cmd_tdata;
    logic                   s0_cmd_tvalid,  s1_cmd_tvalid;
    logic                   s0_cmd_tlast,   s1_cmd_tlast;
    logic                   s0_cmd_tready,  s1_cmd_tready;
    logic [WDATA_WIDTH-1:0] s0_wdata_tdata, s1_wdata_tdata;
    logic                   s0_wdata_tvalid, s1_wdata_tvalid;
    logic                   s0_wdata_tready, s1_wdata_tready;
    logic [CMD_WIDTH-1:0]   m_cmd_tdata;
    logic                   m_cmd_tvalid, m_cmd_tlast, m_cmd_tready;
    logic [WDATA_WIDTH-1:0] m_wdata_tdata;
    logic                   m_wdata_tvalid, m_wdata_tready;

    modport slave (
        input  s0_cmd_tdata, s0_cmd_tvalid, s0_cmd_tlast,
        input  s1_cmd_tdata, s1_cmd_tvalid, s1_cmd_tlast,
        output s0_cmd_tready, s1_cmd_tready,
        input  s0_wdata_tdata, s0_wdata_tvalid, s1_wdata_tdata, s1_wdata_tvalid,
        output s0_wdata_tready, s1_wdata_tready,
        output m_cmd_tdata, m_cmd_tvalid, m_cmd_tlast,
        input  m_cmd_tready,
        output m_wdata_tdata, m_wdata_tvalid,
        input  m_wdata_tready
    );

    modport master (
        output s0_cmd_tdata, s0_cmd_tvalid, s0_cmd_tlast,
        output s1_cmd_tdata, s1_cmd_tvalid, s1_cmd_tlast,
        input  s0_cmd_tready, s1_cmd_tready,
        output s0_wdata_tdata, s0_wdata_tvalid, s1_wdata_tdata, s1_wdata_tvalid,
        input  s0_wdata_tready, s1_wdata_tready,
        input  m_cmd_tdata, m_cmd_tvalid, m_cmd_tlast,
        output m_cmd_tready,
        input  m_wdata_tdata, m_wdata_tvalid,
        output m_wdata_tready
    );
endinterface

// File: rtl/ddr4_cmd_arbiter.sv
// ddr4_cmd_arbiter
// Merges two requester DDR4 command streams and a periodic refresh onto one
// command stream. Grants are held for a whole packet (until tlast). Write data
// is steered from the requester whose WR-bearing beat went out, in command
// order, using a small requester-ID queue.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       requester cmd/wdata streams in, m_cmd/m_wdata out
//   refresh_enable    enables the refresh interval counter
//   trefi             refresh interval in cycles (0 disables refresh)
//   refresh_pending   number of queued refreshes (saturates at 7)
//   refresh_overflow  sticky: a refresh was lost at saturation
module ddr4_cmd_arbiter #(
    parameter int         CMD_WIDTH   = 128,
    parameter int         WDATA_WIDTH = 512,
    parameter int         WDQ_DEPTH   = 4,
    parameter logic [2:0] CMD_WR      = 3'd4,
    parameter logic [2:0] CMD_REF     = 3'd1
) (
    input  logic                clk,
    input  logic                rst,
    ddr4_cmd_arbiter_if.slave   bus,
    input  logic                refresh_enable,
    input  logic [15:0]         trefi,
    output logic [2:0]          refresh_pending,
    output logic                refresh_overflow
);
    localparam int PW = $clog2(WDQ_DEPTH);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, REF} state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;     // 1: s1 wins a tie in IDLE
    logic [WDQ_DEPTH-1:0] ids_q, ids_d;       // one requester-ID bit per entry
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]          occ_q, occ_d;
    logic [15:0]          rcnt_q, rcnt_d;
    logic [2:0]           pend_q, pend_d;
    logic                 ovf_q, ovf_d;

    logic [CMD_WIDTH-1:0] sel_data, cmd_data;
    logic                 sel_valid, sel_last, in_gnt, cur_wr, full, empty, stall;
    logic                 cmd_valid, cmd_last, cmd_hs, push, pop, head, wd_valid;
    logic                 ref_run, ref_wrap, ref_hs;

    function automatic logic has_wr(input logic [CMD_WIDTH-1:0] d);
        has_wr = 1'b0;
        for (int k = 0; k < 4; k++)
            if (d[32*k +: 3] == CMD_WR) has_wr = 1'b1;
    endfunction

    always_comb begin
        in_gnt    = (state_q == GNT0) || (state_q == GNT1);
        sel_data  = (state_q == GNT1) ? bus.s1_cmd_tdata  : bus.s0_cmd_tdata;
        sel_valid = (state_q == GNT1) ? bus.s1_cmd_tvalid : bus.s0_cmd_tvalid;
        sel_last  = (state_q == GNT1) ? bus.s1_cmd_tlast  : bus.s0_cmd_tlast;
        cur_wr    = has_wr(sel_data);
        full      = (occ_q == (PW+1)'(WDQ_DEPTH));
        empty     = (occ_q == '0);
        // A WR beat cannot go out without a free ID slot; other beats flow on.
        stall     = full && cur_wr;

        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_last  = 1'b0;
        if (in_gnt) begin
            cmd_valid = sel_valid && !stall;
            cmd_data  = sel_data;
            cmd_last  = sel_last;
        end else if (state_q == REF) begin
            cmd_valid = 1'b1;
            cmd_data  = CMD_WIDTH'(CMD_REF);
            cmd_last  = 1'b1;
        end
        bus.m_cmd_tvalid  = cmd_valid;
        bus.m_cmd_tdata   = cmd_valid ? cmd_data : '0;
        bus.m_cmd_tlast   = cmd_valid && cmd_last;
        bus.s0_cmd_tready = (state_q == GNT0) && !stall && bus.m_cmd_tready;
        bus.s1_cmd_tready = (state_q == GNT1) && !stall && bus.m_cmd_tready;
        cmd_hs            = cmd_valid && bus.m_cmd_tready;
        push              = cmd_hs && in_gnt && cur_wr;
        ref_hs            = cmd_hs && (state_q == REF);

        // Write data comes only from the requester at the head of the ID queue.
        head                = ids_q[rptr_q];
        wd_valid            = !empty && (head ? bus.s1_wdata_tvalid : bus.s0_wdata_tvalid);
        bus.m_wdata_tvalid  = wd_valid;
        bus.m_wdata_tdata   = wd_valid ? (head ? bus.s1_wdata_tdata : bus.s0_wdata_tdata) : '0;
        bus.s0_wdata_tready = !empty && !head && bus.m_wdata_tready;
        bus.s1_wdata_tready = !empty &&  head && bus.m_wdata_tready;
        pop                 = wd_valid && bus.m_wdata_tready;

        ids_d  = ids_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            ids_d[wptr_q] = (state_q == GNT1);
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PW+1)'(1);
            2'b01:   occ_d = occ_q - (PW+1)'(1);
            default: occ_d = occ_q;
        endcase

        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (pend_q != 3'd0)
                    state_d = REF;
                else if (bus.s0_cmd_tvalid && bus.s1_cmd_tvalid)
                    state_d = prio_q ? GNT1 : GNT0;
                else if (bus.s0_cmd_tvalid)
                    state_d = GNT0;
                else if (bus.s1_cmd_tvalid)
                    state_d = GNT1;
            end
            GNT0: if (cmd_hs && cmd_last) begin state_d = IDLE; prio_d = 1'b1; end
            GNT1: if (cmd_hs && cmd_last) begin state_d = IDLE; prio_d = 1'b0; end
            REF:  if (cmd_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Refresh interval counter; >= keeps it recoverable if trefi shrinks.
        ref_run  = refresh_enable && (trefi != 16'd0);
        ref_wrap = ref_run && (rcnt_q >= trefi - 16'd1);
        rcnt_d   = (ref_run && !ref_wrap) ? rcnt_q + 16'd1 : 16'd0;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        if (ref_wrap && !ref_hs) begin
            if (pend_q == 3'd7) ovf_d  = 1'b1;
            else                pend_d = pend_q + 3'd1;
        end else if (!ref_wrap && ref_hs) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        ids_q <= ids_d;
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            rcnt_q  <= 16'd0;
            pend_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign refresh_pending  = pend_q;
    assign refresh_overflow = ovf_q;
endmodule

// File: tb/tb_ddr4_cmd_arbiter.sv
// Testbench for ddr4_cmd_arbiter: drives both requesters and the refresh
// controls, and compares the m_cmd / m_wdata streams against expected beats
// queued as stimulus is issued.
module tb_ddr4_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        refresh_enable;
    logic [15:0] trefi;
    logic [2:0]  refresh_pending;
    logic        refresh_overflow;

    ddr4_cmd_arbiter_if #(.CMD_WIDTH(128), .WDATA_WIDTH(512)) bus ();

    ddr4_cmd_arbiter #(
        .CMD_WIDTH(128), .WDATA_WIDTH(512), .WDQ_DEPTH(4),
        .CMD_WR(3'd4), .CMD_REF(3'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .refresh_enable(refresh_enable),
        .trefi(trefi),
        .refresh_pending(refresh_pending),
        .refresh_overflow(refresh_overflow)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    bit           mon_on  = 1'b1;
    bit           wd1_done, c5_done;
    logic [128:0] exp_cmd[$];
    logic [511:0] exp_wd[$];
    int           hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int src, input int pkt, input int beat,
                                        input logic [3:0] wrm);
        logic [127:0] d;
        for (int k = 0; k < 4; k++)
            d[32*k +: 32] = {4'(src + 1), 8'(pkt), 8'(beat), 9'(k), (wrm[k] ? 3'd4 : 3'd2)};
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int i, input logic [127:0] d, input logic l);
        if (i == 0) begin
            bus.s0_cmd_tdata = d; bus.s0_cmd_tlast = l; bus.s0_cmd_tvalid = 1'b1;
        end else begin
            bus.s1_cmd_tdata = d; bus.s1_cmd_tlast = l; bus.s1_cmd_tvalid = 1'b1;
        end
        @(negedge clk);
        while (!(i == 0 ? bus.s0_cmd_tready : bus.s1_cmd_tready)) @(negedge clk);
        @(posedge clk);
        #1;
        if (i == 0) bus.s0_cmd_tvalid = 1'b0;
        else        bus.s1_cmd_tvalid = 1'b0;
    endtask

    task automatic send_wd(input int i, input logic [511:0] d);
        if (i == 0) begin bus.s0_wdata_tdata = d; bus.s0_wdata_tvalid = 1'b1; end
        else        begin bus.s1_wdata_tdata = d; bus.s1_wdata_tvalid = 1'b1; end
        @(negedge clk);
        while (!(i == 0 ? bus.s0_wdata_tready : bus.s1_wdata_tready)) @(negedge clk);
        @(posedge clk);
        #1;
        if (i == 0) bus.s0_wdata_tvalid = 1'b0;
        else        bus.s1_wdata_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_cmd.size() != 0 || exp_wd.size() != 0) && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 512'(exp_cmd.size() + exp_wd.size()), 512'd0);
    endtask

    // Scoreboard side: every handshake on an output stream pops one expectation.
    initial begin
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (mon_on && bus.m_cmd_tvalid && bus.m_cmd_tready) begin
                hs_cyc.push_back(cyc);
                if (exp_cmd.size() == 0) check("cmd_extra", 512'd1, 512'd0);
                else begin
                    e = exp_cmd.pop_front();
                    check("cmd_data", 512'(bus.m_cmd_tdata), 512'(e[127:0]));
                    check("cmd_last", 512'(bus.m_cmd_tlast), 512'(e[128]));
                end
            end
            if (mon_on && bus.m_wdata_tvalid && bus.m_wdata_tready) begin
                if (exp_wd.size() == 0) check("wd_extra", 512'd1, 512'd0);
                else check("wd_data", bus.m_wdata_tdata, exp_wd.pop_front());
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [511:0] d0, d1, dq;
        rst = 1'b1; refresh_enable = 1'b0; trefi = 16'd0;
        bus.s0_cmd_tdata = '0; bus.s0_cmd_tvalid = 1'b0; bus.s0_cmd_tlast = 1'b0;
        bus.s1_cmd_tdata = '0; bus.s1_cmd_tvalid = 1'b0; bus.s1_cmd_tlast = 1'b0;
        bus.s0_wdata_tdata = '0; bus.s0_wdata_tvalid = 1'b0;
        bus.s1_wdata_tdata = '0; bus.s1_wdata_tvalid = 1'b0;
        bus.m_cmd_tready = 1'b1; bus.m_wdata_tready = 1'b1;

        // Reset state
        tick(2);
        @(negedge clk);
        check("rst_m_cmd_tvalid", 512'(bus.m_cmd_tvalid), 512'd0);
        check("rst_m_cmd_tdata", 512'(bus.m_cmd_tdata), 512'd0);
        check("rst_s0_cmd_tready", 512'(bus.s0_cmd_tready), 512'd0);
        check("rst_m_wdata_tvalid", 512'(bus.m_wdata_tvalid), 512'd0);
        check("rst_s0_wdata_tready", 512'(bus.s0_wdata_tready), 512'd0);
        check("rst_pending", 512'(refresh_pending), 512'd0);
        check("rst_overflow", 512'(refresh_overflow), 512'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Round-robin with 2-beat packets
        hs_cyc.delete();
        for (int p = 0; p < 5; p++)
            for (int b = 0; b < 2; b++)
                exp_cmd.push_back({b == 1, mk(p % 2, p / 2, b, 4'b0000)});
        fork
            begin
                for (int p = 0; p < 3; p++)
                    for (int b = 0; b < 2; b++) send_cmd(0, mk(0, p, b, 4'b0000), b == 1);
            end
            begin
                for (int p = 0; p < 2; p++)
                    for (int b = 0; b < 2; b++) send_cmd(1, mk(1, p, b, 4'b0000), b == 1);
            end
        join
        wait_drain("rr_drain");
        if (hs_cyc.size() >= 3) begin
            check("rr_burst", 512'(hs_cyc[1] - hs_cyc[0]), 512'd1);
            check("rr_bubble", 512'(hs_cyc[2] - hs_cyc[1]), 512'd2);
        end

        // Refresh does not preempt an 8-beat packet
        trefi = 16'd10; refresh_enable = 1'b1;
        tick(3);
        for (int b = 0; b < 8; b++) exp_cmd.push_back({b == 7, mk(0, 10, b, 4'b0000)});
        exp_cmd.push_back({1'b1, 128'h1});
        for (int b = 0; b < 8; b++) send_cmd(0, mk(0, 10, b, 4'b0000), b == 7);
        check("ref_pending_mid", 512'(refresh_pending), 512'd1);
        check("ref_bubble", 512'(bus.m_cmd_tvalid), 512'd0);
        wait_drain("ref_drain");
        refresh_enable = 1'b0;
        check("ref_pending_after", 512'(refresh_pending), 512'd0);

        // Write data follows command order, even when s1 data arrives first
        d0 = {16{32'h0000_A0A0}};
        d1 = {16{32'h0000_B1B1}};
        exp_cmd.push_back({1'b1, mk(0, 20, 0, 4'b0010)});
        exp_cmd.push_back({1'b1, mk(1, 20, 0, 4'b1000)});
        exp_wd.push_back(d0);
        exp_wd.push_back(d1);
        wd1_done = 1'b0;
        fork
            begin send_wd(1, d1); wd1_done = 1'b1; end
        join_none
        tick(2);
        @(negedge clk);
        check("wd_empty_s1_ready", 512'(bus.s1_wdata_tready), 512'd0);
        check("wd_empty_valid", 512'(bus.m_wdata_tvalid), 512'd0);
        tick(1);
        send_cmd(0, mk(0, 20, 0, 4'b0010), 1'b1);
        send_cmd(1, mk(1, 20, 0, 4'b1000), 1'b1);
        tick(2);
        @(negedge clk);
        check("wd_order_s1_ready", 512'(bus.s1_wdata_tready), 512'd0);
        check("wd_order_valid", 512'(bus.m_wdata_tvalid), 512'd0);
        tick(1);
        send_wd(0, d0);
        wait_drain("wd_drain");
        tick(1);
        check("wd_s1_done", 512'(wd1_done), 512'd1);

        // Full ID queue stalls WR beats until a write-data pop frees a slot
        bus.m_wdata_tready = 1'b0;
        dq = {16{32'hC0DE_0005}};
        bus.s0_wdata_tdata = dq; bus.s0_wdata_tvalid = 1'b1;
        for (int b = 0; b < 6; b++) begin
            exp_cmd.push_back({b == 5, mk(0, 30, b, 4'b0001)});
            exp_wd.push_back(dq);
        end
        c5_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 6; b++) send_cmd(0, mk(0, 30, b, 4'b0001), b == 5);
                c5_done = 1'b1;
            end
        join_none
        tick(10);
        @(negedge clk);
        check("full_pass4", 512'(exp_cmd.size()), 512'd2);
        check("full_stall_valid", 512'(bus.m_cmd_tvalid), 512'd0);
        check("full_stall_ready", 512'(bus.s0_cmd_tready), 512'd0);
        check("full_stall_data", 512'(bus.m_cmd_tdata), 512'd0);
        tick(1);
        bus.m_wdata_tready = 1'b1;
        tick(1);
        bus.m_wdata_tready = 1'b0;
        tick(3);
        @(negedge clk);
        check("full_release_one", 512'(exp_cmd.size()), 512'd1);
        check("full_release_wd", 512'(exp_wd.size()), 512'd5);
        check("full_restall_valid", 512'(bus.m_cmd_tvalid), 512'd0);
        tick(1);
        bus.m_wdata_tready = 1'b1;
        wait_drain("full_drain");
        tick(1);
        bus.s0_wdata_tvalid = 1'b0;
        check("full_cmd_done", 512'(c5_done), 512'd1);

        // Refresh saturation during an endless packet, then drain
        trefi = 16'd3; refresh_enable = 1'b1;
        for (int b = 0; b < 30; b++) exp_cmd.push_back({1'b0, mk(0, 40, b, 4'b0000)});
        exp_cmd.push_back({1'b1, mk(0, 40, 30, 4'b0000)});
        for (int r = 0; r < 7; r++) exp_cmd.push_back({1'b1, 128'h1});
        for (int b = 0; b < 30; b++) send_cmd(0, mk(0, 40, b, 4'b0000), 1'b0);
        check("sat_pending", 512'(refresh_pending), 512'd7);
        check("sat_overflow", 512'(refresh_overflow), 512'd1);
        refresh_enable = 1'b0;
        send_cmd(0, mk(0, 40, 30, 4'b0000), 1'b1);
        wait_drain("sat_drain");
        check("sat_pending_after", 512'(refresh_pending), 512'd0);
        check("sat_ovf_sticky", 512'(refresh_overflow), 512'd1);
        @(negedge clk);
        check("sat_idle", 512'(bus.m_cmd_tvalid), 512'd0);
        tick(1);

        // Reset in the middle of a packet with a non-empty ID queue
        mon_on = 1'b0;
        trefi = 16'd2; refresh_enable = 1'b1;
        bus.s0_cmd_tdata = mk(0, 50, 0, 4'b0001); bus.s0_cmd_tlast = 1'b0;
        bus.s0_cmd_tvalid = 1'b1;
        tick(6);
        check("mr_pending_pre", 512'(refresh_pending), 512'd3);
        check("mr_wready_pre", 512'(bus.s0_wdata_tready), 512'd1);
        rst = 1'b1;
        refresh_enable = 1'b0;
        bus.s0_cmd_tdata = mk(0, 51, 0, 4'b0000); bus.s0_cmd_tlast = 1'b1;
        bus.s1_cmd_tdata = mk(1, 51, 0, 4'b0000); bus.s1_cmd_tlast = 1'b1;
        bus.s1_cmd_tvalid = 1'b1;
        tick(1);
        @(negedge clk);
        check("mr_m_cmd_tvalid", 512'(bus.m_cmd_tvalid), 512'd0);
        check("mr_s0_cmd_tready", 512'(bus.s0_cmd_tready), 512'd0);
        check("mr_s1_cmd_tready", 512'(bus.s1_cmd_tready), 512'd0);
        check("mr_m_wdata_tvalid", 512'(bus.m_wdata_tvalid), 512'd0);
        check("mr_s0_wdata_tready", 512'(bus.s0_wdata_tready), 512'd0);
        check("mr_pending", 512'(refresh_pending), 512'd0);
        check("mr_overflow", 512'(refresh_overflow), 512'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_s0_first", 512'(bus.s0_cmd_tready), 512'd1);
        check("mr_s1_wait", 512'(bus.s1_cmd_tready), 512'd0);
        check("mr_data", 512'(bus.m_cmd_tdata), 512'(mk(0, 51, 0, 4'b0000)));
        tick(1);
        bus.s0_cmd_tvalid = 1'b0;
        bus.s1_cmd_tvalid = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
